// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - select sequencer for a 4-to-1 mux: dwell, sample pulse, sweep/continuous scan
// Optional channel masking is enabled by defining MUX_SCAN_MASK_EN.
module mux_sel_scanner #(
  parameter int DWELL_W    = 4,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         chan_mask,
  output logic               s1,
  output logic               s0,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state, state_nx;
  logic [1:0]         sel, sel_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [DWELL_W-1:0] dwell_q, dwell_nx;
  logic [3:0]         mask_q, mask_nx;
  logic               stop_pend, stop_pend_nx;
  logic               done_q, done_nx;
  logic [3:0]         start_mask;
  logic [2:0]         up_hit;

`ifdef MUX_SCAN_MASK_EN
  assign start_mask = chan_mask;
`else
  // chan_mask is read but cannot clear any channel without the mask feature
  assign start_mask = chan_mask | 4'b1111;
`endif

  function automatic logic [1:0] first_idx(input logic [3:0] m);
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) first_idx = 2'(i);
    end
  endfunction

  // {found, index} of the lowest enabled channel strictly above cur
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
    next_above = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_above = {1'b1, 2'(i)};
    end
  endfunction

  assign up_hit = next_above(mask_q, sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      cnt       <= '0;
      dwell_q   <= '0;
      mask_q    <= 4'd0;
      stop_pend <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      cnt       <= cnt_nx;
      dwell_q   <= dwell_nx;
      mask_q    <= mask_nx;
      stop_pend <= stop_pend_nx;
      done_q    <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    cnt_nx       = cnt;
    dwell_nx     = dwell_q;
    mask_nx      = mask_q;
    stop_pend_nx = stop_pend;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        // a same-cycle stop is dropped: nothing is running yet to stop
        if (start && (start_mask != 4'd0)) begin
          state_nx     = DWELL;
          sel_nx       = first_idx(start_mask);
          cnt_nx       = dwell;
          dwell_nx     = dwell;
          mask_nx      = start_mask;
          stop_pend_nx = 1'b0;
        end
      end
      DWELL: begin
        if (stop) stop_pend_nx = 1'b1;
        if (cnt == '0) state_nx = SAMPLE;
        else           cnt_nx   = cnt - CNT_ONE;
      end
      SAMPLE: begin
        if (stop_pend || stop) begin
          state_nx     = IDLE;
          done_nx      = 1'b1;
          stop_pend_nx = 1'b0;
        end else if (up_hit[2]) begin
          state_nx = DWELL;
          sel_nx   = up_hit[1:0];
          cnt_nx   = dwell_q;
        end else if (CONTINUOUS) begin
          state_nx = DWELL;
          sel_nx   = first_idx(mask_q);
          cnt_nx   = dwell_q;
        end else begin
          state_nx     = IDLE;
          done_nx      = 1'b1;
          stop_pend_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign s1           = sel[1];
  assign s0           = sel[0];
  assign sample_valid = (state == SAMPLE);
  assign busy         = (state != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - table-driven bench for mux_sel_scanner (continuous and single-sweep instances)
module tb_mux_sel_scanner;

`ifdef MUX_SCAN_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, stop0, start1, stop1;
  logic [3:0] dwell, mask;
  logic       c_s1, c_s0, c_sv, c_busy, c_done;
  logic       o_s1, o_s0, o_sv, o_busy, o_done;
  logic [3:0] abcd = 4'b1010;  // d=1 c=0 b=1 a=0

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux_sel_scanner #(.DWELL_W(4), .CONTINUOUS(1'b1)) dut_cont (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .dwell(dwell), .chan_mask(mask),
    .s1(c_s1), .s0(c_s0), .sample_valid(c_sv), .busy(c_busy), .done(c_done)
  );

  mux_sel_scanner #(.DWELL_W(4), .CONTINUOUS(1'b0)) dut_once (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .dwell(dwell), .chan_mask(mask),
    .s1(o_s1), .s0(o_s0), .sample_valid(o_sv), .busy(o_busy), .done(o_done)
  );

  typedef struct {
    bit         w;
    bit         st;
    bit         sp;
    logic [3:0] dw;
    logic [3:0] mk;
    logic [1:0] sel;
    bit         sv;
    bit         busy;
    bit         done;
    bit         ychk;
    bit         y;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic add(input bit w, input bit st, input bit sp, input logic [3:0] dw,
                     input logic [3:0] mk, input logic [1:0] sel, input bit sv,
                     input bit busy, input bit done, input bit ychk, input bit y);
    vec_t v;
    v.w = w; v.st = st; v.sp = sp; v.dw = dw; v.mk = mk;
    v.sel = sel; v.sv = sv; v.busy = busy; v.done = done; v.ychk = ychk; v.y = y;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    for (int i = 0; i < vq.size(); i++) begin
      v      = vq[i];
      dwell  = v.dw;
      mask   = v.mk;
      start0 = !v.w && v.st;
      stop0  = !v.w && v.sp;
      start1 = v.w && v.st;
      stop1  = v.w && v.sp;
      @(posedge clk);
      #1;
      start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
      if (!v.w) begin
        check($sformatf("%s[%0d] sel", tag, i), {c_s1, c_s0}, v.sel);
        check($sformatf("%s[%0d] sample_valid", tag, i), c_sv, v.sv);
        check($sformatf("%s[%0d] busy", tag, i), c_busy, v.busy);
        check($sformatf("%s[%0d] done", tag, i), c_done, v.done);
        if (v.ychk) check($sformatf("%s[%0d] y", tag, i), abcd[{c_s1, c_s0}], v.y);
      end else begin
        check($sformatf("%s[%0d] sel", tag, i), {o_s1, o_s0}, v.sel);
        check($sformatf("%s[%0d] sample_valid", tag, i), o_sv, v.sv);
        check($sformatf("%s[%0d] busy", tag, i), o_busy, v.busy);
        check($sformatf("%s[%0d] done", tag, i), o_done, v.done);
      end
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    dwell = 4'd0; mask = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset cont sel", {c_s1, c_s0}, 0);
    check("reset cont sv", c_sv, 0);
    check("reset cont busy", c_busy, 0);
    check("reset cont done", c_done, 0);
    check("reset once sel", {o_s1, o_s0}, 0);
    check("reset once sv", o_sv, 0);
    check("reset once busy", o_busy, 0);
    check("reset once done", o_done, 0);

    // dwell=2 continuous sweep; dwell/mask inputs change after start to prove capture
    for (int i = 0; i < 20; i++)
      add(0, i == 0, 0, (i == 0) ? 4'd2 : 4'd7, (i == 0) ? 4'hF : 4'h0,
          2'((i / 4) % 4), (i % 4) == 3, 1, 0, (i % 4) == 3, ((i / 4) % 2) == 1);
    add(0, 0, 1, 4'd2, 4'hF, 2'd0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 0, 0, 0, 0, 0);
    run_table("sweep");

    // stop mid-DWELL on ch1, start ignored while busy, then restart from ch0
    add(0, 1, 0, 4'd2, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 4'd2, 4'hF, 2'd1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 4'd0, 4'hF, 2'd1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd2, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 4'd2, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 4'd2, 4'hF, 2'd0, 0, 0, 0, 0, 0);
    run_table("stop");

    // single sweep, dwell=1: period 3, ends holding ch3
    for (int i = 0; i < 12; i++)
      add(1, i == 0, 0, 4'd1, 4'hF, 2'(i / 3), (i % 3) == 2, 1, 0, 0, 0);
    add(1, 0, 0, 4'd1, 4'hF, 2'd3, 0, 0, 1, 0, 0);
    add(1, 0, 0, 4'd1, 4'hF, 2'd3, 0, 0, 0, 0, 0);
    run_table("once");

    // dwell=0 boundary: sample every 2 cycles
`ifdef MUX_SCAN_MASK_EN
    add(0, 1, 0, 4'd0, 4'b1010, 2'd1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd3, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd3, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 4'd0, 4'b1010, 2'd1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd1, 0, 0, 0, 0, 0);
`else
    for (int i = 0; i < 8; i++)
      add(0, i == 0, 0, 4'd0, 4'b1010, 2'(i / 2), (i % 2) == 1, 1, 0, 0, 0);
    add(0, 0, 1, 4'd0, 4'b1010, 2'd3, 0, 0, 1, 0, 0);
    add(0, 0, 0, 4'd0, 4'b1010, 2'd3, 0, 0, 0, 0, 0);
`endif
    run_table("dwell0");

    // run into DWELL on ch2, then reset asynchronously mid-cycle
    for (int i = 0; i < 12; i++)
      add(0, i == 0, 0, 4'd3, 4'hF, 2'(i / 5), (i % 5) == 4, 1, 0, 0, 0);
    run_table("prereset");
    #2;
    rst = 1'b1;
    #1;
    check("async rst sel", {c_s1, c_s0}, 0);
    check("async rst busy", c_busy, 0);
    check("async rst sv", c_sv, 0);
    check("async rst done", c_done, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post rst[%0d] done", i), c_done, 0);
      check($sformatf("post rst[%0d] busy", i), c_busy, 0);
    end

    // empty mask start (ignored only with masking), stop in IDLE, start+stop together
    add(0, 1, 0, 4'd0, 4'h0, 2'd0, 0, !MASK_EN, 0, 0, 0);
    add(0, 0, 1, 4'd0, 4'h0, 2'd0, !MASK_EN, !MASK_EN, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'h0, 2'd0, 0, 0, !MASK_EN, 0, 0);
    add(0, 0, 0, 4'd0, 4'h0, 2'd0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 4'd0, 4'hF, 2'd0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'hF, 2'd0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'hF, 2'd1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 4'd0, 4'hF, 2'd1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'd0, 4'hF, 2'd1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 4'd0, 4'hF, 2'd1, 0, 0, 0, 0, 0);
    run_table("idle_req");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
